trace_collector: RTL
====================

Name: trace_collector

Overview:
- Consumer side of the control-flow trace filter path.
- Every cycle it takes one retired-instruction trace item (pc, instr, drop flag) from the core trace port.
- Items flagged for drop are discarded and counted. Kept items (branch/jump/return/WFI) are buffered in a FIFO, tagged with the number of items skipped before them.
- The FIFO drains over a valid/ready stream towards the trace DMA/host interface.

Parameters:
- PC_WIDTH, 64, width of program counter field.
- FIFO_DEPTH, 16, number of buffered kept items; power of 2, minimum 2.
- SKIP_CNT_WIDTH, 16, width of skipped-item counter; saturating.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  trace item present this cycle; no backpressure towards core.
- in_pc  input  PC_WIDTH  pc of retired instruction.
- in_instr  input  32  retired instruction word.
- in_drop  input  1  1 = item is not control flow, discard and count.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head.
- out_pc  output  PC_WIDTH  head pc.
- out_instr  output  32  head instruction.
- out_skip_cnt  output  SKIP_CNT_WIDTH  items skipped (dropped or lost) since previous delivered item.
- fill_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a kept item was lost because FIFO was full.
- clear_overflow  input  1  single-cycle pulse, clears overflow.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; rd/wr pointers 0; fill_level 0.
  - Skip counter 0; overflow 0.
  - out_valid 0; out_pc, out_instr, out_skip_cnt all 0.
  - Reset mid-transfer discards all buffered items; no partial output.
- Input, evaluated per cycle with in_valid=1:
  - in_drop=1: skip_cnt <= sat(skip_cnt+1). No push.
  - in_drop=0, push allowed: write {in_pc, in_instr, skip_cnt} at wr_ptr; skip_cnt <= 0.
  - in_drop=0, push blocked (full and no pop this cycle): item lost; overflow <= 1; skip_cnt <= sat(skip_cnt+1). The next delivered item therefore accounts for the loss.
  - in_valid=0: no action; skip_cnt holds.
- Saturation: skip_cnt stops at 2^SKIP_CNT_WIDTH-1 and never wraps.
- Pop: occurs when out_valid && out_ready; rd_ptr advances.
- Full with pop and push in the same cycle: push succeeds and occupancy is unchanged. This is not an overflow.
- Empty with push: no bypass. out_valid rises the cycle after the push edge, so write-to-output latency is 1 cycle.
- Empty with out_ready=1: nothing happens.
- out_valid = (fill_level != 0). Output fields are registered/read from the head entry and stay stable while out_valid && !out_ready.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. full/empty are derived from the occupancy counter. fill_level ranges 0..FIFO_DEPTH.
- overflow:
  - Set by a lost push; cleared by clear_overflow.
  - Set and clear in the same cycle: set wins.
  - Affects nothing except the flag.
- Throughput: sustains one push and one pop per cycle indefinitely.

Test Plan:
- Reset check: assert rst mid-stream with 5 items buffered -> out_valid=0, fill_level=0, overflow=0, outputs 0 immediately. After release, the next kept item arrives with out_skip_cnt=0.
- Filtering and count: 3 dropped items, then kept pc=0x1000 instr=0x0000006F, out_ready=1 -> one output pc=0x1000 with out_skip_cnt=3, 1 cycle after its input. The next kept item with no drops between carries out_skip_cnt=0.
- Backpressure and overflow: out_ready=0, 18 consecutive kept items (DEPTH=16) -> fill_level=16 and overflow=1. Then out_ready=1 and one kept item -> 16 outputs with skip_cnt 0, then the final item with out_skip_cnt=2.
- Full with simultaneous pop/push: FIFO full, out_ready=1, kept item pushed the same cycle -> fill_level stays 16, overflow stays 0, item delivered in order.
- Saturation: SKIP_CNT_WIDTH=4, 20 dropped items then 1 kept -> out_skip_cnt=15.
- Overflow clear race: clear_overflow pulsed in the same cycle as a lost push -> overflow=1. Pulse again with no loss -> overflow=0 next cycle.

Source files
------------

// File: rtl/trace_collector.sv
// Control-flow trace collector: counts dropped trace items and buffers kept items,
// each tagged with its preceding skip count, in a FIFO drained over valid/ready.
module trace_collector #(
    parameter int PC_WIDTH       = 64,
    parameter int FIFO_DEPTH     = 16,
    parameter int SKIP_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [PC_WIDTH-1:0]           in_pc,
    input  logic [31:0]                   in_instr,
    input  logic                          in_drop,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_WIDTH-1:0]           out_pc,
    output logic [31:0]                   out_instr,
    output logic [SKIP_CNT_WIDTH-1:0]     out_skip_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SKIP_CNT_WIDTH-1:0] SKIP_MAX = '1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]       pc;
        logic [31:0]               instr;
        logic [SKIP_CNT_WIDTH-1:0] skip;
    } entry_t;

    entry_t                    mem [FIFO_DEPTH];
    entry_t                    head;
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          count, count_next;
    logic [SKIP_CNT_WIDTH-1:0] skip_cnt, skip_next;
    logic                      keep_req, push, pop, lost, full;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign keep_req = in_valid && !in_drop;
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = keep_req && (!full || pop);
    assign lost     = keep_req && !push;

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        skip_next  = skip_cnt;
        count_next = count;
        if ((in_valid && in_drop) || lost) begin
            if (skip_cnt != SKIP_MAX)
                skip_next = skip_cnt + SKIP_CNT_WIDTH'(1);
        end else if (push) begin
            skip_next = '0;
        end
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            skip_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= count_next;
            skip_cnt <= skip_next;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (lost)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; entries are only visible once the counter marks them valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, skip: skip_cnt};
    end

    assign head         = mem[rd_ptr];
    assign fill_level   = count;
    assign out_valid    = (count != '0);
    // Gate the head entry so an empty FIFO presents all-zero fields.
    assign out_pc       = out_valid ? head.pc    : '0;
    assign out_instr    = out_valid ? head.instr : '0;
    assign out_skip_cnt = out_valid ? head.skip  : '0;

endmodule
